// File: rtl/bellek_hakemi_if.sv
// bellek_hakemi_if: l1b/l1v requester signals and the shared memory request/response bus
interface bellek_hakemi_if #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32
);
  logic                  l1b_chip_select_n_i;
  logic [ADRES_BIT-1:0]  l1b_adres_i;
  logic                  l1b_bekle_o;
  logic [VERI_BIT-1:0]   l1b_deger_o;
  logic                  l1v_chip_select_n_i;
  logic                  l1v_yaz_gecerli_i;
  logic [ADRES_BIT-1:0]  l1v_adres_i;
  logic [VERI_BIT-1:0]   l1v_yaz_deger_i;
  logic [VERI_BIT/8-1:0] l1v_yaz_maske_i;
  logic                  l1v_bekle_o;
  logic [VERI_BIT-1:0]   l1v_deger_o;
  logic                  bellek_istek_gecerli_o;
  logic                  bellek_istek_hazir_i;
  logic [ADRES_BIT-1:0]  bellek_adres_o;
  logic                  bellek_yaz_gecerli_o;
  logic [VERI_BIT-1:0]   bellek_yaz_deger_o;
  logic [VERI_BIT/8-1:0] bellek_yaz_maske_o;
  logic                  bellek_yanit_gecerli_i;
  logic [VERI_BIT-1:0]   bellek_yanit_deger_i;
  modport slave (
    input  l1b_chip_select_n_i, l1b_adres_i,
    input  l1v_chip_select_n_i, l1v_yaz_gecerli_i, l1v_adres_i, l1v_yaz_deger_i, l1v_yaz_maske_i,
    input  bellek_istek_hazir_i, bellek_yanit_gecerli_i, bellek_yanit_deger_i,
    output l1b_bekle_o, l1b_deger_o, l1v_bekle_o, l1v_deger_o,
    output bellek_istek_gecerli_o, bellek_adres_o, bellek_yaz_gecerli_o, bellek_yaz_deger_o,
    output bellek_yaz_maske_o
  );
  modport master (
    output l1b_chip_select_n_i, l1b_adres_i,
    output l1v_chip_select_n_i, l1v_yaz_gecerli_i, l1v_adres_i, l1v_yaz_deger_i, l1v_yaz_maske_i,
    output bellek_istek_hazir_i, bellek_yanit_gecerli_i, bellek_yanit_deger_i,
    input  l1b_bekle_o, l1b_deger_o, l1v_bekle_o, l1v_deger_o,
    input  bellek_istek_gecerli_o, bellek_adres_o, bellek_yaz_gecerli_o, bellek_yaz_deger_o,
    input  bellek_yaz_maske_o
  );
endinterface

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: arbitrates l1b fetches and l1v data accesses onto one valid/ready memory port.
// Define BELLEK_HAKEMI_ROUND_ROBIN_EN for round-robin contention instead of fixed l1v priority.
module bellek_hakemi #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  bellek_hakemi_if.slave bus
);
  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT, TAMAM} durum_t;
  durum_t                durum_q, durum_d;
  logic                  grant_q, grant_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic                  yaz_q, yaz_d;
  logic [VERI_BIT-1:0]   wdeger_q, wdeger_d;
  logic [VERI_BIT/8-1:0] maske_q, maske_d;
  logic [VERI_BIT-1:0]   b_deger_q, b_deger_d;
  logic [VERI_BIT-1:0]   v_deger_q, v_deger_d;
  logic                  b_ist, v_ist, sec_v, kabul, okuma_bitti;
  assign b_ist = ~bus.l1b_chip_select_n_i;
  assign v_ist = ~bus.l1v_chip_select_n_i;
  // grant_q (1 = l1v) also serves as the last-grant pointer
`ifdef BELLEK_HAKEMI_ROUND_ROBIN_EN
  assign sec_v = v_ist & (~b_ist | ~grant_q);
`else
  assign sec_v = v_ist;
`endif
  assign kabul       = (durum_q == BOSTA) & (b_ist | v_ist);
  assign okuma_bitti = (durum_q == YANIT) & bus.bellek_yanit_gecerli_i & ~yaz_q;
  always_comb begin
    durum_d   = kabul ? ISTEK :
                (durum_q == ISTEK && bus.bellek_istek_hazir_i) ? YANIT :
                (durum_q == YANIT && bus.bellek_yanit_gecerli_i) ? TAMAM :
                (durum_q == TAMAM) ? BOSTA : durum_q;
    grant_d   = kabul ? sec_v : grant_q;
    adres_d   = kabul ? (sec_v ? bus.l1v_adres_i : bus.l1b_adres_i) : adres_q;
    yaz_d     = kabul ? (sec_v & bus.l1v_yaz_gecerli_i) : yaz_q;
    wdeger_d  = kabul ? (sec_v ? bus.l1v_yaz_deger_i : '0) : wdeger_q;
    maske_d   = kabul ? (sec_v ? bus.l1v_yaz_maske_i : '0) : maske_q;
    b_deger_d = (okuma_bitti & ~grant_q) ? bus.bellek_yanit_deger_i : b_deger_q;
    v_deger_d = (okuma_bitti & grant_q) ? bus.bellek_yanit_deger_i : v_deger_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q   <= 1'b0;
      adres_q   <= '0;
      yaz_q     <= 1'b0;
      wdeger_q  <= '0;
      maske_q   <= '0;
      b_deger_q <= '0;
      v_deger_q <= '0;
    end else begin
      grant_q   <= grant_d;
      adres_q   <= adres_d;
      yaz_q     <= yaz_d;
      wdeger_q  <= wdeger_d;
      maske_q   <= maske_d;
      b_deger_q <= b_deger_d;
      v_deger_q <= v_deger_d;
    end
  end
  assign bus.l1b_bekle_o            = b_ist & ~((durum_q == TAMAM) & ~grant_q);
  assign bus.l1v_bekle_o            = v_ist & ~((durum_q == TAMAM) & grant_q);
  assign bus.l1b_deger_o            = b_deger_q;
  assign bus.l1v_deger_o            = v_deger_q;
  assign bus.bellek_istek_gecerli_o = (durum_q == ISTEK);
  assign bus.bellek_adres_o         = adres_q;
  assign bus.bellek_yaz_gecerli_o   = yaz_q;
  assign bus.bellek_yaz_deger_o     = wdeger_q;
  assign bus.bellek_yaz_maske_o     = maske_q;
endmodule
